// File: rtl/decodeur_rgb_code.sv
// decodeur_rgb_code: RGB 3:3:2 pixel -> colour code 0..27, 2-stage valid/ready pipe.
// Optional histogram counter (cible/nb_cible) built when DECODEUR_RGB_HISTO_EN is defined.
module decodeur_rgb_code #(
  parameter int unsigned NOIR_VAUT_UN = 0,
  parameter int unsigned LARG_CPT     = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          rouge,
  input  logic [2:0]          vert,
  input  logic [1:0]          bleu,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4:0]          code,
  output logic                erreur,
  input  logic                effacer_cpt,
  output logic [LARG_CPT-1:0] nb_erreurs
`ifdef DECODEUR_RGB_HISTO_EN
  ,
  input  logic [4:0]          cible,
  output logic [LARG_CPT-1:0] nb_cible
`endif
);

  localparam logic [LARG_CPT-1:0] CPT_MAX = '1;

  logic                s1_valid_q;
  logic                s1_valid_d;
  logic [1:0]          lr_q;
  logic [1:0]          lr_d;
  logic [1:0]          lv_q;
  logic [1:0]          lv_d;
  logic [1:0]          lb_q;
  logic [1:0]          lb_d;
  logic                inv_q;
  logic                inv_d;

  logic                s2_valid_q;
  logic                s2_valid_d;
  logic [4:0]          code_q;
  logic [4:0]          code_d;
  logic                erreur_q;
  logic                erreur_d;

  logic [LARG_CPT-1:0] nb_err_q;
  logic [LARG_CPT-1:0] nb_err_d;

  logic                s1_advance;
  logic                in_fire;
  logic                out_fire;

  logic [1:0]          lr_in;
  logic [1:0]          lv_in;
  logic [1:0]          lb_in;
  logic                inv_in;

  logic [4:0]          code_calc;
  logic                noir_s1;

  // Handshake: stage 1 drains into stage 2 whenever stage 2 is empty or leaving.
  assign s1_advance = !s2_valid_q || out_ready;
  assign in_ready   = !s1_valid_q || s1_advance;
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = s2_valid_q && out_ready;

  // Map raw channel levels to 0..2 and flag any level outside the palette.
  always_comb begin
    lr_in  = 2'd0;
    lv_in  = 2'd0;
    lb_in  = 2'd0;
    inv_in = 1'b0;
    case (rouge)
      3'd0:    lr_in = 2'd0;
      3'd3:    lr_in = 2'd1;
      3'd7:    lr_in = 2'd2;
      default: inv_in = 1'b1;
    endcase
    case (vert)
      3'd0:    lv_in = 2'd0;
      3'd3:    lv_in = 2'd1;
      3'd7:    lv_in = 2'd2;
      default: inv_in = 1'b1;
    endcase
    case (bleu)
      2'd0:    lb_in = 2'd0;
      2'd1:    lb_in = 2'd1;
      2'd3:    lb_in = 2'd2;
      default: inv_in = 1'b1;
    endcase
  end

  // Base-3 recombination of the stage-1 levels; max 27 fits in 5 bits.
  always_comb begin
    code_calc = 5'(lr_q) * 5'd9
              + 5'(lv_q) * 5'd3
              + 5'(lb_q)
              + 5'd1;
    noir_s1   = (lr_q == 2'd0)
             && (lv_q == 2'd0)
             && (lb_q == 2'd0);
  end

  // Next state of both pipeline stages and the error counter.
  always_comb begin
    s1_valid_d = s1_valid_q;
    lr_d       = lr_q;
    lv_d       = lv_q;
    lb_d       = lb_q;
    inv_d      = inv_q;
    s2_valid_d = s2_valid_q;
    code_d     = code_q;
    erreur_d   = erreur_q;
    nb_err_d   = nb_err_q;

    if (in_fire) begin
      s1_valid_d = 1'b1;
      lr_d       = lr_in;
      lv_d       = lv_in;
      lb_d       = lb_in;
      inv_d      = inv_in;
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end

    if (s1_advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        if (inv_q) begin
          code_d   = 5'd0;
          erreur_d = 1'b1;
        end else if (noir_s1 && (NOIR_VAUT_UN == 0)) begin
          code_d   = 5'd0;
          erreur_d = 1'b0;
        end else begin
          code_d   = code_calc;
          erreur_d = 1'b0;
        end
      end
    end

    if (effacer_cpt) begin
      nb_err_d = '0;
    end else if (in_fire && inv_in && (nb_err_q != CPT_MAX)) begin
      nb_err_d = nb_err_q + 1'b1;
    end
  end

  // Pipeline and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      lr_q       <= 2'd0;
      lv_q       <= 2'd0;
      lb_q       <= 2'd0;
      inv_q      <= 1'b0;
      s2_valid_q <= 1'b0;
      code_q     <= 5'd0;
      erreur_q   <= 1'b0;
      nb_err_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      lr_q       <= lr_d;
      lv_q       <= lv_d;
      lb_q       <= lb_d;
      inv_q      <= inv_d;
      s2_valid_q <= s2_valid_d;
      code_q     <= code_d;
      erreur_q   <= erreur_d;
      nb_err_q   <= nb_err_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign code       = code_q;
  assign erreur     = erreur_q;
  assign nb_erreurs = nb_err_q;

`ifdef DECODEUR_RGB_HISTO_EN
  logic [LARG_CPT-1:0] nb_cib_q;
  logic [LARG_CPT-1:0] nb_cib_d;

  // Count emitted codes matching cible, error codes included.
  always_comb begin
    nb_cib_d = nb_cib_q;
    if (effacer_cpt) begin
      nb_cib_d = '0;
    end else if (out_fire && (code_q == cible)
                 && (nb_cib_q != CPT_MAX)) begin
      nb_cib_d = nb_cib_q + 1'b1;
    end
  end

  // Histogram register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nb_cib_q <= '0;
    end else begin
      nb_cib_q <= nb_cib_d;
    end
  end

  assign nb_cible = nb_cib_q;
`else
  logic unused_out_fire;
  assign unused_out_fire = out_fire;
`endif

endmodule

// File: tb/tb_decodeur_rgb_code.sv
// tb_decodeur_rgb_code: scoreboard bench for decodeur_rgb_code.
// Two instances: defaults, and NOIR_VAUT_UN=1 with 4-bit counters.
module tb_decodeur_rgb_code;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        out_ready;
  logic        effacer_cpt;
  logic [2:0]  rouge;
  logic [2:0]  vert;
  logic [1:0]  bleu;

  logic        in_ready;
  logic        out_valid;
  logic [4:0]  code;
  logic        erreur;
  logic [15:0] nb_erreurs;

  logic        in_ready2;
  logic        out_valid2;
  logic [4:0]  code2;
  logic        erreur2;
  logic [3:0]  nb_erreurs2;

`ifdef DECODEUR_RGB_HISTO_EN
  logic [4:0]  cible;
  logic [15:0] nb_cible;
  logic [3:0]  nb_cible2;
`endif

  always #5 clk = ~clk;

  decodeur_rgb_code #(
    .NOIR_VAUT_UN(0),
    .LARG_CPT(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .rouge(rouge),
    .vert(vert),
    .bleu(bleu),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .code(code),
    .erreur(erreur),
    .effacer_cpt(effacer_cpt),
    .nb_erreurs(nb_erreurs)
`ifdef DECODEUR_RGB_HISTO_EN
    ,
    .cible(cible),
    .nb_cible(nb_cible)
`endif
  );

  decodeur_rgb_code #(
    .NOIR_VAUT_UN(1),
    .LARG_CPT(4)
  ) dut2 (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_ready(in_ready2),
    .rouge(rouge),
    .vert(vert),
    .bleu(bleu),
    .out_valid(out_valid2),
    .out_ready(out_ready),
    .code(code2),
    .erreur(erreur2),
    .effacer_cpt(effacer_cpt),
    .nb_erreurs(nb_erreurs2)
`ifdef DECODEUR_RGB_HISTO_EN
    ,
    .cible(cible),
    .nb_cible(nb_cible2)
`endif
  );

  typedef struct {
    logic [4:0] c;
    logic       e;
    logic [4:0] c2;
    logic       lat;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [2:0] r;
    logic [2:0] v;
    logic [1:0] b;
    logic [4:0] c;
    logic       e;
  } vec_t;

  vec_t dir_tab[8] = '{
    '{3'd7, 3'd7, 2'd3, 5'd27, 1'b0},
    '{3'd3, 3'd0, 2'd1, 5'd11, 1'b0},
    '{3'd0, 3'd3, 2'd0, 5'd4,  1'b0},
    '{3'd0, 3'd0, 2'd0, 5'd0,  1'b0},
    '{3'd2, 3'd0, 2'd0, 5'd0,  1'b1},
    '{3'd0, 3'd0, 2'd2, 5'd0,  1'b1},
    '{3'd7, 3'd3, 2'd0, 5'd22, 1'b0},
    '{3'd0, 3'd7, 2'd1, 5'd8,  1'b0}
  };

  exp_t q[$];
  exp_t mx;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   acc      = 0;
  logic lat_mode = 1'b0;

  logic       held_v = 1'b0;
  logic [4:0] held_c;
  logic       held_e;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Independent reference: search the level tables.
  function automatic logic [5:0] model(input logic [2:0] r,
                                       input logic [2:0] v,
                                       input logic [1:0] b,
                                       input bit noir1);
    logic [2:0] t3[3];
    logic [1:0] t2[3];
    int ir;
    int iv;
    int ib;
    t3[0] = 3'd0; t3[1] = 3'd3; t3[2] = 3'd7;
    t2[0] = 2'd0; t2[1] = 2'd1; t2[2] = 2'd3;
    ir = -1; iv = -1; ib = -1;
    for (int i = 0; i < 3; i++) begin
      if (r == t3[i]) ir = i;
      if (v == t3[i]) iv = i;
      if (b == t2[i]) ib = i;
    end
    if (ir < 0 || iv < 0 || ib < 0) return {1'b1, 5'd0};
    if (ir == 0 && iv == 0 && ib == 0 && !noir1) return 6'd0;
    return {1'b0, 5'(ir * 9 + iv * 3 + ib + 1)};
  endfunction

  task automatic send(input logic [2:0] r,
                      input logic [2:0] v,
                      input logic [1:0] b,
                      input logic [4:0] c,
                      input logic       e,
                      input logic [4:0] c2);
    int   n;
    exp_t x;
    n        = 0;
    rouge    = r;
    vert     = v;
    bleu     = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=in_ready_low required=accept");
    end else begin
      x.c   = c;
      x.e   = e;
      x.c2  = c2;
      x.lat = lat_mode;
      x.cyc = cyc;
      q.push_back(x);
      acc++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [2:0] r,
                        input logic [2:0] v,
                        input logic [1:0] b);
    logic [5:0] m0;
    logic [5:0] m1;
    m0 = model(r, v, b, 1'b0);
    m1 = model(r, v, b, 1'b1);
    send(r, v, b, m0[4:0], m0[5], m1[4:0]);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cpt();
    effacer_cpt = 1'b1;
    @(posedge clk);
    #1;
    effacer_cpt = 1'b0;
  endtask

  // Monitor: output stability under back-pressure and scoreboard pops.
  always @(negedge clk) begin
    if (!reset_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v && out_valid) begin
        check("hold_code", code, held_c);
        check("hold_erreur", erreur, held_e);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%0d required=none", code);
        end else begin
          mx = q.pop_front();
          check("code", code, mx.c);
          check("erreur", erreur, mx.e);
          check("valid2", out_valid2, 1);
          check("code_noir1", code2, mx.c2);
          check("erreur2", erreur2, mx.e);
          if (mx.lat) check("latency", cyc - mx.cyc, 2);
        end
      end
      held_v = out_valid && !out_ready;
      held_c = code;
      held_e = erreur;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    effacer_cpt = 1'b0;
    rouge       = 3'd0;
    vert        = 3'd0;
    bleu        = 2'd0;
`ifdef DECODEUR_RGB_HISTO_EN
    cible       = 5'd0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_code", code, 0);
    check("rst_erreur", erreur, 0);
    check("rst_nb_erreurs", nb_erreurs, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid2", out_valid2, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Directed vectors back to back, latency checked.
    lat_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(dir_tab[i].r, dir_tab[i].v, dir_tab[i].b,
           dir_tab[i].c, dir_tab[i].e,
           (dir_tab[i].r == 0 && dir_tab[i].v == 0
            && dir_tab[i].b == 0) ? 5'd1 : dir_tab[i].c);
    end
    drain();
    check("dir_nb_erreurs", nb_erreurs, 2);

    // Full sweep.
    clear_cpt();
    check("clr_nb_erreurs", nb_erreurs, 0);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] p;
      p = 8'(i);
      send_m(p[7:5], p[4:2], p[1:0]);
    end
    drain();
    check("sweep_nb_erreurs", nb_erreurs, 229);
    check("sweep_nb_erreurs_sat4", nb_erreurs2, 15);

    // 20 invalid pixels, then clear racing an increment.
    clear_cpt();
    for (int i = 0; i < 20; i++) send_m(3'd1, 3'd0, 2'd0);
    drain();
    check("inv20_nb_erreurs", nb_erreurs, 20);
    check("inv20_nb_erreurs_sat4", nb_erreurs2, 15);
    effacer_cpt = 1'b1;
    send_m(3'd1, 3'd1, 2'd2);
    effacer_cpt = 1'b0;
    @(negedge clk);
    check("clr_prio_nb_erreurs", nb_erreurs, 0);
    check("clr_prio_nb_erreurs2", nb_erreurs2, 0);
    drain();

    // Back-pressure: 4 pixels offered, out_ready low for 5 cycles.
    lat_mode  = 1'b0;
    acc       = 0;
    out_ready = 1'b0;
    fork
      begin
        send(3'd7, 3'd7, 2'd3, 5'd27, 1'b0, 5'd27);
        send(3'd0, 3'd0, 2'd1, 5'd2,  1'b0, 5'd2);
        send(3'd3, 3'd3, 2'd3, 5'd15, 1'b0, 5'd15);
        send(3'd7, 3'd0, 2'd0, 5'd19, 1'b0, 5'd19);
      end
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("stall_accepted", acc, 2);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("stall_total", acc, 4);

    // Reset with two pixels in flight.
    out_ready = 1'b0;
    send(3'd0, 3'd7, 2'd3, 5'd9, 1'b0, 5'd9);
    send(3'd3, 3'd0, 2'd1, 5'd11, 1'b0, 5'd11);
    check("pre_rst_out_valid", out_valid, 1);
    reset_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_out_valid2", out_valid2, 0);
    q.delete();
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_no_output", out_valid, 0);
    end

`ifdef DECODEUR_RGB_HISTO_EN
    clear_cpt();
    cible = 5'd27;
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) send_m(3'd7, 3'd7, 2'd3);
      else if (i % 3 == 1) send_m(3'd3, 3'd0, 2'd1);
      else send_m(3'd2, 3'd2, 2'd2);
    end
    drain();
    check("histo_27", nb_cible, 10);
    check("histo_27_dut2", nb_cible2, 10);
    clear_cpt();
    cible = 5'd0;
    send_m(3'd1, 3'd0, 2'd0);
    send_m(3'd0, 3'd0, 2'd0);
    send_m(3'd0, 3'd5, 2'd0);
    send_m(3'd0, 3'd0, 2'd2);
    drain();
    check("histo_0", nb_cible, 4);
    check("histo_0_dut2", nb_cible2, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
